// File: rtl/shift_pair_unit.sv
// Multi-cycle shifter over the register pair {A,B}: one bit position per cycle,
// with logical, arithmetic, rotate and serial-in fill modes in either direction.
module shift_pair_unit #(
   parameter int WIDTH = 8,
   localparam int SW = $clog2(2*WIDTH+1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Ld_A,
   input  logic             Ld_B,
   input  logic [WIDTH-1:0] D_in,
   input  logic             Start,
   input  logic             Dir,
   input  logic [1:0]       Mode,
   input  logic [SW-1:0]    Shamt,
   input  logic             Ser_In,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             Ser_Out,
   output logic             Busy,
   output logic             Done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [SW-1:0] MAX_SH = SW'(2*WIDTH);

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [SW-1:0]      cnt;
   logic               dir_q;
   logic [1:0]         mode_q;
   logic [SW-1:0]      sh_clamped;
   logic               fill;
   logic [2*WIDTH-1:0] cat, shifted;

   assign sh_clamped = (Shamt > MAX_SH) ? MAX_SH : Shamt;

   always_comb begin
      fill = 1'b0;
      if (!dir_q) begin
         case (mode_q)
            2'b01:   fill = a_q[WIDTH-1];
            2'b10:   fill = b_q[0];
            2'b11:   fill = Ser_In;
            default: fill = 1'b0;
         endcase
      end else begin
         case (mode_q)
            2'b10:   fill = a_q[WIDTH-1];
            2'b11:   fill = Ser_In;
            default: fill = 1'b0;
         endcase
      end
      cat     = {a_q, b_q};
      shifted = dir_q ? {cat[2*WIDTH-2:0], fill} : {fill, cat[2*WIDTH-1:1]};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         cnt    <= '0;
         dir_q  <= 1'b0;
         mode_q <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               // A load in the same cycle as Start wins; Start is dropped.
               if (Ld_A || Ld_B) begin
                  if (Ld_A) a_q <= D_in;
                  if (Ld_B) b_q <= D_in;
               end else if (Start) begin
                  dir_q  <= Dir;
                  mode_q <= Mode;
                  cnt    <= sh_clamped;
                  state  <= (sh_clamped != '0) ? SHIFT : DONE;
               end
            end
            SHIFT: begin
               {a_q, b_q} <= shifted;
               cnt        <= cnt - SW'(1);
               if (cnt == SW'(1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign A       = a_q;
   assign B       = b_q;
   assign Busy    = (state == SHIFT);
   assign Done    = (state == DONE);
   assign Ser_Out = (state != IDLE && dir_q) ? a_q[WIDTH-1] : b_q[0];

endmodule

// File: tb/tb_shift_pair_unit.sv
// Directed bench for shift_pair_unit: each Start pushes the expected result into
// a scoreboard that a monitor checks against A/B and the Busy count on Done.
module tb_shift_pair_unit;

   localparam int WIDTH = 8;
   localparam int SW = $clog2(2*WIDTH+1);

   logic             Clk = 1'b0;
   logic             Reset, Ld_A, Ld_B, Start, Dir, Ser_In;
   logic [WIDTH-1:0] D_in;
   logic [1:0]       Mode;
   logic [SW-1:0]    Shamt;
   logic [WIDTH-1:0] A, B;
   logic             Ser_Out, Busy, Done;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int               busy;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   busy_cnt = 0;

   shift_pair_unit #(.WIDTH(WIDTH)) dut (
      .Clk(Clk), .Reset(Reset), .Ld_A(Ld_A), .Ld_B(Ld_B), .D_in(D_in),
      .Start(Start), .Dir(Dir), .Mode(Mode), .Shamt(Shamt), .Ser_In(Ser_In),
      .A(A), .B(B), .Ser_Out(Ser_Out), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: counts Busy cycles and compares against the scoreboard on each Done.
   always @(negedge Clk) begin
      if (Reset) busy_cnt = 0;
      else begin
         if (Busy) busy_cnt++;
         if (Done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("result_A", 32'(A), 32'(e.a));
               chk("result_B", 32'(B), 32'(e.b));
               chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      Ld_A = 1'b1; D_in = a; tick();
      Ld_A = 1'b0; Ld_B = 1'b1; D_in = b; tick();
      Ld_B = 1'b0;
   endtask

   task automatic run(input logic d, input logic [1:0] m, input logic [SW-1:0] sh,
                      input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                      input int ebusy, input logic hold_ld, input logic chk_so,
                      input logic exp_so);
      exp_t e;
      bit   seen;
      e.a = ea; e.b = eb; e.busy = ebusy;
      sb.push_back(e);
      Start = 1'b1; Dir = d; Mode = m; Shamt = sh;
      tick();
      Start = 1'b0; Dir = ~d; Mode = ~m; Shamt = '0;
      if (chk_so) chk("ser_out", 32'(Ser_Out), 32'(exp_so));
      Ld_A = hold_ld; D_in = 8'hFF;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (Done) begin seen = 1'b1; break; end
         tick();
      end
      Ld_A = 1'b0;
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      tick();
   endtask

   initial begin
      Reset = 1'b1; Ld_A = 0; Ld_B = 0; Start = 0; Dir = 0; Mode = 0;
      Shamt = '0; Ser_In = 0; D_in = '0;
      tick(); tick();
      Reset = 1'b0;
      chk("reset_A", 32'(A), 32'h0);
      chk("reset_B", 32'(B), 32'h0);
      chk("reset_busy", 32'(Busy), 32'h0);
      chk("reset_done", 32'(Done), 32'h0);
      chk("reset_ser_out", 32'(Ser_Out), 32'h0);

      load(8'h07, 8'h59);
      run(1'b0, 2'b00, 5'd3, 8'h00, 8'hEB, 3, 1'b0, 1'b1, 1'b1);
      load(8'h80, 8'h00);
      run(1'b0, 2'b01, 5'd4, 8'hF8, 8'h00, 4, 1'b0, 1'b0, 1'b0);
      load(8'h12, 8'h34);
      run(1'b1, 2'b10, 5'd4, 8'h23, 8'h41, 4, 1'b0, 1'b0, 1'b0);
      load(8'h12, 8'h34);
      run(1'b1, 2'b10, 5'd31, 8'h12, 8'h34, 16, 1'b0, 1'b0, 1'b0);
      load(8'h80, 8'h00);
      run(1'b1, 2'b00, 5'd1, 8'h00, 8'h00, 1, 1'b0, 1'b1, 1'b1);
      load(8'h00, 8'h00);
      Ser_In = 1'b1;
      run(1'b0, 2'b11, 5'd2, 8'hC0, 8'h00, 2, 1'b0, 1'b0, 1'b0);
      run(1'b0, 2'b11, 5'd0, 8'hC0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
      Ser_In = 1'b0;
      load(8'h12, 8'h34);
      run(1'b1, 2'b10, 5'd4, 8'h23, 8'h41, 4, 1'b1, 1'b0, 1'b0);
      load(8'h34, 8'h12);
      run(1'b0, 2'b00, 5'd16, 8'h00, 8'h00, 16, 1'b0, 1'b0, 1'b0);

      // Reset on the third Busy cycle of a 10-step shift.
      load(8'h07, 8'h59);
      Start = 1'b1; Shamt = 5'd10; Dir = 1'b0; Mode = 2'b00;
      tick();
      Start = 1'b0;
      tick(); tick();
      chk("busy_before_reset", 32'(Busy), 32'h1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("midreset_A", 32'(A), 32'h0);
      chk("midreset_B", 32'(B), 32'h0);
      chk("midreset_busy", 32'(Busy), 32'h0);
      chk("midreset_done", 32'(Done), 32'h0);
      chk("midreset_ser_out", 32'(Ser_Out), 32'h0);
      repeat (15) tick();
      chk("post_reset_busy", 32'(Busy), 32'h0);

      Start = 1'b1; Ld_A = 1'b1; D_in = 8'h5A; Shamt = 5'd3;
      tick();
      Start = 1'b0; Ld_A = 1'b0;
      chk("start_ld_A", 32'(A), 32'h5A);
      chk("start_ld_busy", 32'(Busy), 32'h0);
      tick();
      chk("start_ld_busy2", 32'(Busy), 32'h0);
      chk("start_ld_done", 32'(Done), 32'h0);

      repeat (3) tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/shift_pair_unit.md
SHIFT_PAIR_UNIT -- requirements
Module: shift_pair_unit

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each of the two registers A and B; SHALL be >= 2.
REQ-002 Derived localparam SW = $clog2(2*WIDTH+1), width of the shift-amount field.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Ld_A  input  1  load A from D_in.
REQ-006 Ld_B  input  1  load B from D_in.
REQ-007 D_in  input  WIDTH  parallel load data.
REQ-008 Start  input  1  begin a multi-cycle shift of the concatenation {A,B}.
REQ-009 Dir  input  1  0 = shift right (toward B[0]), 1 = shift left (toward A[WIDTH-1]); sampled at Start.
REQ-010 Mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-in from Ser_In; sampled at Start.
REQ-011 Shamt  input  SW  number of single-bit shift steps; sampled at Start.
REQ-012 Ser_In  input  1  fill bit for Mode 11, sampled every SHIFT cycle.
REQ-013 A, B  output  WIDTH each  register contents.
REQ-014 Ser_Out  output  1  bit that the next step would shift out: B[0] if the latched Dir = 0, A[WIDTH-1] if it = 1; B[0] in IDLE.
REQ-015 Busy  output  1  high while in SHIFT.
REQ-016 Done  output  1  one-cycle pulse when an operation completes.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE; all outputs registered or decoded from registered state.
REQ-018 IDLE: Ld_A/Ld_B load D_in on the next edge; both may load in the same cycle.
REQ-019 IDLE, Start=1 with no load: latch Dir, Mode, min(Shamt, 2*WIDTH) into a down-counter. Go to SHIFT if the count is nonzero, else to DONE.
REQ-020 IDLE, Start and any Ld asserted in the same cycle: the load takes effect, Start is ignored, state stays IDLE.
REQ-021 SHIFT: {A,B} shifts exactly one position per cycle, and the counter decrements. Go to DONE on the cycle the counter reaches 0, so there are exactly N shift cycles for a clamped amount N.
REQ-022 Right-shift fill bit into A[WIDTH-1]: logical 0, arithmetic A[WIDTH-1], rotate B[0], serial Ser_In.
REQ-023 Left-shift fill bit into B[0]: logical 0, arithmetic 0, rotate A[WIDTH-1], serial Ser_In.
REQ-024 DONE: Done=1 for exactly one cycle, Busy=0, then unconditional return to IDLE.
REQ-025 Ld_A, Ld_B and Start are ignored in SHIFT and DONE.
REQ-026 Latency: Start sampled at edge k. For N > 0, Busy is high for cycles k+1..k+N and Done is high in cycle k+N+1. For N = 0, Done is high in cycle k+1, Busy never rises, and A and B are unchanged.
REQ-027 Shamt values above 2*WIDTH are clamped to 2*WIDTH. Logical shift by 2*WIDTH yields all zeros; rotate by 2*WIDTH yields the original value.

Reset
REQ-028 Reset dominates all other inputs in every state, including mid-SHIFT: next edge gives A=0, B=0, counter=0, state IDLE, Busy=0, Done=0, Ser_Out=0.
REQ-029 After Reset, the latched Dir is 0 and the latched Mode is 00.

Verification
REQ-030 WIDTH=8; load A=0x07, B=0x59; Start Dir=0 Mode=00 Shamt=3 -> Busy high 3 cycles, Done next cycle, A=0x00, B=0xEB.
REQ-031 Load A=0x80, B=0x00; Start Dir=0 Mode=01 Shamt=4 -> A=0xF8, B=0x00.
REQ-032 Load A=0x12, B=0x34; Start Dir=1 Mode=10 Shamt=4 -> A=0x23, B=0x41; Shamt=31 (clamped to 16) -> A=0x12, B=0x34 after 16 Busy cycles.
REQ-033 A=B=0; Start Dir=0 Mode=11 Shamt=2, Ser_In=1 -> A=0xC0, B=0x00. Shamt=0 -> Done in cycle k+1, Busy never high, A and B unchanged.
REQ-034 Start with Shamt=10, assert Reset on the 3rd Busy cycle -> next edge A=B=0, Busy=0, Done never pulses. Ld_A during SHIFT -> no effect on A.
REQ-035 Start and Ld_A in the same IDLE cycle with D_in=0x5A -> A=0x5A, state stays IDLE, Busy stays 0.
